ptmp_dispatcher: RTL

Sequencing front end for the Ptmp/IM calculator in the BOOST interaction datapath. For one SNP triple it walks all 27 genotype cells (i,j,k ∈ {0,1,2}), fetches the joint count and the three pairwise-marginal floats from external tables, and issues one operand set to the calculator. It then waits for that cell's result and forwards IM/tao with a cell index to the downstream accumulator. Only one cell is in flight at a time, because the calculator has a single counter and no backpressure.

---
 rtl/ptmp_dispatcher.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ptmp_dispatcher.sv
// ptmp_dispatcher: walks the 27 genotype cells of one SNP triple, fetches the
// joint count and pairwise marginals, issues them to the Ptmp/IM calculator,
// waits for that cell's result and forwards it with its cell index.
// Optional feature: define PTMP_DISPATCH_TIMEOUT_EN to add a WAIT watchdog.
module ptmp_dispatcher #(
  parameter int DATA_WIDTH  = 16,
  parameter int FLOAT_WIDTH = 32,
  parameter int TIMEOUT     = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  n_in,
  output logic                   busy,
  output logic                   done,
  output logic [4:0]             jt_addr,
  input  logic [DATA_WIDTH-1:0]  jt_rdata,
  output logic [3:0]             pab_addr,
  output logic [3:0]             pbc_addr,
  output logic [3:0]             pca_addr,
  input  logic [FLOAT_WIDTH-1:0] pab_rdata,
  input  logic [FLOAT_WIDTH-1:0] pbc_rdata,
  input  logic [FLOAT_WIDTH-1:0] pca_rdata,
  output logic [FLOAT_WIDTH-1:0] Pab_out,
  output logic [FLOAT_WIDTH-1:0] Pbc_out,
  output logic [FLOAT_WIDTH-1:0] Pca_out,
  output logic [DATA_WIDTH-1:0]  joint_table_out,
  output logic [DATA_WIDTH-1:0]  n_out,
  output logic                   calc_valid_out,
  input  logic                   calc_done_in,
  input  logic [FLOAT_WIDTH-1:0] IM_in,
  input  logic [FLOAT_WIDTH-1:0] tao_in,
  output logic                   res_valid,
  output logic [4:0]             res_idx,
  output logic [FLOAT_WIDTH-1:0] res_IM,
  output logic [FLOAT_WIDTH-1:0] res_tao,
  output logic                   res_last,
  output logic                   res_err
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, ISSUE, WAIT, EMIT, FIN} state_t;

  state_t     state, state_nxt;
  logic [1:0] ci, cj, ck;
  logic [4:0] cell_idx;
  logic       done_prev;
  logic       done_edge;
  logic       timeout_hit;

  // Table addresses follow the cell counter directly; the tables return data
  // one cycle later, which is exactly the CAPTURE cycle.
  assign cell_idx  = 5'(ci) * 5'd9 + 5'(cj) * 5'd3 + 5'(ck);
  assign jt_addr   = cell_idx;
  assign pab_addr  = 4'(ci) * 4'd3 + 4'(cj);
  assign pbc_addr  = 4'(cj) * 4'd3 + 4'(ck);
  assign pca_addr  = 4'(ck) * 4'd3 + 4'(ci);

  // A level already high when WAIT is entered has done_prev set, so only a
  // true low-to-high transition counts.
  assign done_edge = calc_done_in & ~done_prev;

  assign busy           = (state != IDLE) && (state != FIN);
  assign done           = (state == FIN);
  assign calc_valid_out = (state == ISSUE);
  assign res_valid      = (state == EMIT);
  assign res_last       = (state == EMIT) && (cell_idx == 5'd26);

`ifdef PTMP_DISPATCH_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wdog;

  // Watchdog counts WAIT cycles; held at zero elsewhere so it clears on entry.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wdog <= '0;
    else                      wdog <= wdog + 1'b1;
  end

  assign timeout_hit = (state == WAIT) && !done_edge && (wdog == WDW'(TIMEOUT - 1));

  // Error flag is a result field: updated only when a cell's result is taken.
  always_ff @(posedge clk) begin
    if (rst)                                           res_err <= 1'b0;
    else if (state == WAIT && (done_edge || timeout_hit)) res_err <= timeout_hit;
  end
`else
  assign timeout_hit = 1'b0;
  assign res_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing: one cell in flight at a time.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_edge || timeout_hit) state_nxt = EMIT;
      EMIT:    state_nxt = (cell_idx == 5'd26) ? FIN : READ;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: counter, operand capture, result capture, done edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_prev       <= 1'b0;
      ci              <= '0;
      cj              <= '0;
      ck              <= '0;
      n_out           <= '0;
      Pab_out         <= '0;
      Pbc_out         <= '0;
      Pca_out         <= '0;
      joint_table_out <= '0;
      res_idx         <= '0;
      res_IM          <= '0;
      res_tao         <= '0;
    end else begin
      done_prev <= calc_done_in;
      unique case (state)
        IDLE: if (start) begin
          n_out <= n_in;
          ci    <= '0;
          cj    <= '0;
          ck    <= '0;
        end
        CAPTURE: begin
          Pab_out         <= pab_rdata;
          Pbc_out         <= pbc_rdata;
          Pca_out         <= pca_rdata;
          joint_table_out <= jt_rdata;
        end
        WAIT: begin
          if (done_edge) begin
            res_IM  <= IM_in;
            res_tao <= tao_in;
            res_idx <= cell_idx;
          end else if (timeout_hit) begin
            res_IM  <= '0;
            res_tao <= '0;
            res_idx <= cell_idx;
          end
        end
        EMIT: if (cell_idx != 5'd26) begin
          // k fastest, carry into j then i
          if (ck == 2'd2) begin
            ck <= '0;
            if (cj == 2'd2) begin
              cj <= '0;
              ci <= ci + 2'd1;
            end else begin
              cj <= cj + 2'd1;
            end
          end else begin
            ck <= ck + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
